// File: rtl/cdiv_iter.sv
// rtl/cdiv_iter.sv - iterative complex/real signed divider, one quotient bit per cycle
module cdiv_iter #(
    parameter int W = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            complex_real,
    input  logic [W-1:0]    Real_A,
    input  logic [W-1:0]    Im_A,
    input  logic [W-1:0]    Real_B,
    input  logic [W-1:0]    Im_B,
    output logic [2*W-1:0]  out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            div_by_zero,
    output logic            overflow
);
    localparam int PW = 2 * W;
    localparam int N1 = PW + 1;
    localparam int CW = $clog2(PW + 1);

    typedef enum logic [2:0] {IDLE, MULT, SUM, DIV, DONE} state_t;

    state_t                state_q, state_d;
    logic signed [W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic                  cmplx_q, cmplx_d;
    logic signed [PW-1:0]  ac_q, ac_d, bd_q, bd_d, bc_q, bc_d, ad_q, ad_d;
    logic signed [PW-1:0]  cc_q, cc_d, dd_q, dd_d;
    logic [PW-1:0]         num_re_q, num_re_d, num_im_q, num_im_d;
    logic [PW-1:0]         rem_re_q, rem_re_d, rem_im_q, rem_im_d;
    logic [PW-1:0]         den_q, den_d;
    logic                  neg_re_q, neg_re_d, neg_im_q, neg_im_d;
    logic                  zero_q, zero_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         out_q, out_d;
    logic                  out_valid_q, out_valid_d, dbz_q, dbz_d, ovf_q, ovf_d;

    logic signed [N1-1:0]  n_re, n_im;
    logic signed [PW-1:0]  c_ext;
    logic [2*PW-1:0]       step_re, step_im;
    logic [W:0]            sat_re, sat_im;

    // Returns {next remainder, next shift register}; the quotient bit enters the LSB.
    function automatic logic [2*PW-1:0] div_step(input logic [PW-1:0] rem,
                                                 input logic [PW-1:0] num,
                                                 input logic [PW-1:0] den);
        logic [PW:0] sh;
        logic [PW:0] diff;
        logic        qbit;
        sh   = {rem, num[PW-1]};
        diff = sh - {1'b0, den};
        qbit = ~diff[PW];
        return {(qbit ? diff[PW-1:0] : sh[PW-1:0]), num[PW-2:0], qbit};
    endfunction

    // Returns {saturated, value} for a magnitude with a separate sign.
    function automatic logic [W:0] saturate(input logic [PW-1:0] mag, input logic neg);
        logic [PW-1:0] maxp;
        logic [W:0]    r;
        maxp = {{(W+1){1'b0}}, {(W-1){1'b1}}};
        if (!neg) begin
            if (mag > maxp) r = {1'b1, 1'b0, {(W-1){1'b1}}};
            else            r = {1'b0, mag[W-1:0]};
        end else begin
            if (mag > maxp + {{(PW-1){1'b0}}, 1'b1}) r = {1'b1, 1'b1, {(W-1){1'b0}}};
            else r = {1'b0, (~mag[W-1:0]) + {{(W-1){1'b0}}, 1'b1}};
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
        cmplx_d     = cmplx_q;
        ac_d = ac_q; bd_d = bd_q; bc_d = bc_q; ad_d = ad_q; cc_d = cc_q; dd_d = dd_q;
        num_re_d    = num_re_q;
        num_im_d    = num_im_q;
        rem_re_d    = rem_re_q;
        rem_im_d    = rem_im_q;
        den_d       = den_q;
        neg_re_d    = neg_re_q;
        neg_im_d    = neg_im_q;
        zero_d      = zero_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        n_re        = '0;
        n_im        = '0;
        c_ext       = '0;
        step_re     = '0;
        step_im     = '0;
        sat_re      = '0;
        sat_im      = '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = Real_A;
                    b_d     = Im_A;
                    c_d     = Real_B;
                    d_d     = Im_B;
                    cmplx_d = complex_real;
                    state_d = MULT;
                end
            end
            MULT: begin
                ac_d    = PW'(a_q) * PW'(c_q);
                bd_d    = PW'(b_q) * PW'(d_q);
                bc_d    = PW'(b_q) * PW'(c_q);
                ad_d    = PW'(a_q) * PW'(d_q);
                cc_d    = PW'(c_q) * PW'(c_q);
                dd_d    = PW'(d_q) * PW'(d_q);
                state_d = SUM;
            end
            SUM: begin
                if (cmplx_q) begin
                    n_re     = N1'(ac_q) + N1'(bd_q);
                    n_im     = N1'(bc_q) - N1'(ad_q);
                    den_d    = $unsigned(cc_q) + $unsigned(dd_q);
                    neg_re_d = n_re[N1-1];
                    neg_im_d = n_im[N1-1];
                end else begin
                    n_re     = N1'(a_q);
                    c_ext    = PW'(c_q);
                    den_d    = c_ext[PW-1] ? -c_ext : c_ext;
                    neg_re_d = a_q[W-1] ^ c_q[W-1];
                    neg_im_d = 1'b0;
                end
                // |n| <= 2^(PW-1), so the low PW bits negate without loss
                num_re_d = n_re[N1-1] ? (~n_re[PW-1:0]) + {{(PW-1){1'b0}}, 1'b1} : n_re[PW-1:0];
                num_im_d = n_im[N1-1] ? (~n_im[PW-1:0]) + {{(PW-1){1'b0}}, 1'b1} : n_im[PW-1:0];
                rem_re_d = '0;
                rem_im_d = '0;
                zero_d   = (den_d == '0);
                cnt_d    = CW'(PW);
                state_d  = DIV;
            end
            DIV: begin
                if (zero_q) begin
                    out_d       = '0;
                    dbz_d       = 1'b1;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (cnt_q == '0) begin
                    sat_re      = saturate(num_re_q, neg_re_q);
                    sat_im      = saturate(num_im_q, neg_im_q);
                    out_d       = {sat_re[W-1:0], sat_im[W-1:0]};
                    ovf_d       = sat_re[W] | sat_im[W];
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    step_re              = div_step(rem_re_q, num_re_q, den_q);
                    step_im              = div_step(rem_im_q, num_im_q, den_q);
                    {rem_re_d, num_re_d} = step_re;
                    {rem_im_d, num_im_d} = step_im;
                    cnt_d                = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
            cmplx_q     <= 1'b0;
            ac_q <= '0; bd_q <= '0; bc_q <= '0; ad_q <= '0; cc_q <= '0; dd_q <= '0;
            num_re_q    <= '0;
            num_im_q    <= '0;
            rem_re_q    <= '0;
            rem_im_q    <= '0;
            den_q       <= '0;
            neg_re_q    <= 1'b0;
            neg_im_q    <= 1'b0;
            zero_q      <= 1'b0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
            cmplx_q     <= cmplx_d;
            ac_q <= ac_d; bd_q <= bd_d; bc_q <= bc_d; ad_q <= ad_d; cc_q <= cc_d; dd_q <= dd_d;
            num_re_q    <= num_re_d;
            num_im_q    <= num_im_d;
            rem_re_q    <= rem_re_d;
            rem_im_q    <= rem_im_d;
            den_q       <= den_d;
            neg_re_q    <= neg_re_d;
            neg_im_q    <= neg_im_d;
            zero_q      <= zero_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_cdiv_iter.sv
// tb/tb_cdiv_iter.sv - randomized self-checking bench for cdiv_iter against an arithmetic model
module tb_cdiv_iter;
    localparam int W   = 8;
    localparam int LAT = 2 * W + 3;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           complex_real = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   Real_A = '0, Im_A = '0, Real_B = '0, Im_B = '0;
    logic           in_ready, out_valid, div_by_zero, overflow;
    logic [2*W-1:0] out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] out;
        logic        dbz;
        logic        ovf;
        int          acc;
    } exp_t;
    exp_t expq[$];

    cdiv_iter #(.W(W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .complex_real(complex_real), .Real_A(Real_A), .Im_A(Im_A), .Real_B(Real_B),
        .Im_B(Im_B), .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Exact quotient by integer arithmetic (truncating), then clamp to 8-bit signed.
    function automatic logic [17:0] model(input bit m, input int a, input int b,
                                          input int c, input int d);
        longint nre, nim, den, qre, qim;
        bit     o;
        if (m) begin
            nre = longint'(a) * c + longint'(b) * d;
            nim = longint'(b) * c - longint'(a) * d;
            den = longint'(c) * c + longint'(d) * d;
        end else begin
            nre = a;
            nim = 0;
            den = c;
        end
        if (den == 0) return {16'h0000, 2'b10};
        qre = nre / den;
        qim = nim / den;
        o   = 1'b0;
        if (qre > 127) begin qre = 127; o = 1'b1; end
        else if (qre < -128) begin qre = -128; o = 1'b1; end
        if (qim > 127) begin qim = 127; o = 1'b1; end
        else if (qim < -128) begin qim = -128; o = 1'b1; end
        return {qre[7:0], qim[7:0], 1'b0, o};
    endfunction

    // Single compare process: results, latency, hold stability and handshake.
    initial begin
        logic        prev_v;
        logic        prev_r;
        logic [17:0] snap;
        exp_t        e;
        prev_v = 1'b0;
        prev_r = 1'b0;
        snap   = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_v = 1'b0;
                prev_r = 1'b0;
            end else begin
                if (prev_v && prev_r) begin
                    chk("consume_out_valid", out_valid, 0);
                    chk("consume_in_ready", in_ready, 1);
                end else if (out_valid && !prev_v) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_result", expq.size(), 1);
                    end else begin
                        e = expq.pop_front();
                        chk("out", out, e.out);
                        chk("div_by_zero", div_by_zero, e.dbz);
                        chk("overflow", overflow, e.ovf);
                        chk("latency", cyc - e.acc, e.dbz ? 3 : LAT);
                    end
                    snap = {out, div_by_zero, overflow};
                end else if (out_valid && prev_v) begin
                    chk("hold_stable", {out, div_by_zero, overflow}, snap);
                end
                if (out_valid) chk("in_ready_busy", in_ready, 0);
                prev_v = out_valid;
                prev_r = out_ready;
            end
        end
    end

    task automatic accept(input bit m, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
        exp_t        e;
        logic [17:0] r;
        int          n;
        r = model(m, $signed(a), $signed(b), $signed(c), $signed(d));
        n = 0;
        while (!in_ready && n < 200) begin @(posedge clock); #1; n++; end
        chk("wait_in_ready", in_ready, 1);
        complex_real = m;
        Real_A = a; Im_A = b; Real_B = c; Im_B = d;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        e.out = r[17:2];
        e.dbz = r[1];
        e.ovf = r[0];
        e.acc = cyc;
        expq.push_back(e);
        Real_A = 8'($urandom); Im_A = 8'($urandom);
        Real_B = 8'($urandom); Im_B = 8'($urandom);
        complex_real = 1'($urandom);
    endtask

    task automatic run_op(input bit m, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d,
                          input int stall, input bit poke);
        int n;
        out_ready = (stall == 0);
        accept(m, a, b, c, d);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clock); #1; n++; end
        chk("result_timeout", out_valid, 1);
        for (int i = 0; i < stall; i++) begin
            if (poke) in_valid = ~in_valid;
            @(posedge clock); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] a, b, c, d;
        bit         m;

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_flags", {div_by_zero, overflow}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        chk("model_cplx", model(1, 10, 5, 1, 2), {16'h04FD, 2'b00});
        chk("model_real_a", model(0, 100, 0, -7, 0), {16'hF200, 2'b00});
        chk("model_real_b", model(0, -100, 0, 7, 0), {16'hF200, 2'b00});
        chk("model_real_zero_num", model(0, 0, 0, 5, 0), {16'h0000, 2'b00});
        chk("model_dbz", model(1, 3, 4, 0, 0), {16'h0000, 2'b10});
        chk("model_sat", model(0, -128, 0, -1, 0), {16'h7F00, 2'b01});
        chk("model_j", model(1, 127, 0, 0, 1), {16'h0081, 2'b00});

        run_op(1, 8'd10, 8'd5, 8'd1, 8'd2, 0, 0);
        run_op(0, 8'd100, 8'h5A, 8'hF9, 8'h11, 1, 0);
        run_op(0, 8'h9C, 8'h00, 8'd7, 8'h00, 0, 0);
        run_op(0, 8'd0, 8'h33, 8'd5, 8'h00, 2, 0);
        run_op(1, 8'd3, 8'd4, 8'd0, 8'd0, 0, 0);
        run_op(0, 8'd5, 8'd9, 8'd0, 8'd7, 1, 0);
        run_op(1, 8'd127, 8'd0, 8'd0, 8'd1, 0, 0);
        run_op(0, 8'h80, 8'h00, 8'hFF, 8'h00, 5, 1);

        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
            b = 8'($urandom);
            c = 8'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin c = 8'h00; d = 8'h00; end
            if ($urandom_range(0, 7) == 0) c = 8'hFF;
            run_op(m, a, b, c, d, $urandom_range(0, 3), 1'($urandom));
        end

        // Last result carries overflow=1, so an async reset must visibly clear it.
        run_op(0, 8'h80, 8'h00, 8'hFF, 8'h00, 0, 0);
        accept(1, 8'd10, 8'd5, 8'd1, 8'd2);
        repeat (8) @(posedge clock);
        @(negedge clock); #2;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out", out, 0);
        chk("async_rst_flags", {div_by_zero, overflow}, 0);
        expq.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        run_op(1, 8'd10, 8'd5, 8'd1, 8'd2, 0, 0);

        repeat (3) @(posedge clock);
        chk("pending_results", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
